sitcp_tx_arbiter: RTL
=====================

# sitcp_tx_arbiter

Round-robin scheduler that shares the single SiTCP TCP transmit byte stream among `N_SRC` 32-bit packet sources. It grants one source per packet and prefixes each packet with a one-byte source tag. It serializes each payload word MSB-first into `TCP_TX_DATA`/`TCP_TX_WR`, honours `TCP_TX_FULL`, and discards packets in flight when the TCP connection drops. It sits between the user data producers and the SiTCP wrapper, in the `CLK` (`sys_clk`) domain.

## Interface
Parameters:
- `N_SRC`, 4: number of sources, 1..8.
- `TAG_BASE`, 8'hA0: header byte is `TAG_BASE | src_index`. Low 3 bits must be 0.

Ports:
- `CLK` in 1: system clock. This is the single clock.
- `RST` in 1: reset, asynchronous and active-high.
- `src_valid` in N_SRC: per-source word valid.
- `src_data` in 32*N_SRC: source i occupies bits [32i+31:32i].
- `src_last` in N_SRC: word is the final word of its packet.
- `src_ready` out N_SRC: word accepted when `src_valid[i] & src_ready[i]`.
- `TCP_OPEN_ACK` in 1: connection established.
- `TCP_TX_FULL` in 1: SiTCP TX almost-full.
- `TCP_TX_WR` out 1: byte write strobe, registered.
- `TCP_TX_DATA` out 8: byte, registered.
- `pkt_count` out 32: packets fully sent, wraps.
- `drop_count` out 16: packets aborted, saturates at 16'hFFFF.
- `busy` out 1: state != IDLE.

## Operation
States: IDLE, HDR, FETCH, SER, DRAIN.
- **IDLE**
  - If `TCP_OPEN_ACK`=1 and any `src_valid`: grant the first requester at or after `rr_ptr`, searching upward with wrap. Latch it as `gnt`, then go to HDR.
  - If `TCP_OPEN_ACK`=0: no grant is made and no `src_ready` is asserted.
- **HDR**
  - If `TCP_TX_FULL`=0: write `TAG_BASE|gnt`, then go to FETCH.
  - Otherwise hold.
- **FETCH**
  - `src_ready[gnt]`=1, combinational from state and `gnt`.
  - On handshake: capture data and last into `word_r`/`last_r`, set `byte_idx`=0, go to SER.
- **SER**
  - In each cycle with `TCP_TX_FULL`=0: write `word_r[31-8*byte_idx -: 8]` and increment `byte_idx`.
  - After byte 3:
    - If `last_r`: increment `pkt_count`, set `rr_ptr` = (`gnt`+1) mod `N_SRC`, go to IDLE.
    - Else go to FETCH.
- **DRAIN**
  - Entered from HDR, FETCH or SER whenever `TCP_OPEN_ACK`=0. This transition has priority over all others.
  - No further writes are issued.
  - `src_ready[gnt]`=1; accepted words are discarded.
  - Exit to IDLE when a word with `src_last`=1 is accepted, or immediately if `last_r`=1 and that word was already captured.
  - On exit: increment `drop_count` (saturating) and advance `rr_ptr` past `gnt`.
- **Outputs**
  - `src_ready` bits other than `gnt` are always 0.
  - `TCP_TX_WR` is 1 only in the cycle following a write decision.
  - `TCP_TX_DATA` holds its last value when `TCP_TX_WR`=0.
- **Reset values**: state IDLE, `rr_ptr`=0, `gnt`=0, `TCP_TX_WR`=0, `TCP_TX_DATA`=0, counters 0, `src_ready`=0, `busy`=0.
- **Reset mid-packet**: the packet is abandoned with no drop count. Any partial packet already in SiTCP is the host's responsibility.

## Timing
- Request sampled in IDLE at cycle 0 → HDR in cycle 1. With no FULL, the header `TCP_TX_WR` is seen at cycle 2.
- FETCH in cycle 2; `src_ready` is high in the same cycle.
- Bytes are decided in cycles 3–6 and appear on `TCP_TX_WR` in cycles 4–7.
- Steady throughput: 4 bytes per 5 cycles per packet word. A one-word packet takes 7 cycles from request to return to IDLE.
- `TCP_TX_FULL` is sampled in the decision cycle. At most one byte is written after FULL rises, which the SiTCP almost-full margin covers.
- A simultaneous `TCP_OPEN_ACK` fall and FULL release resolves to DRAIN with no write.
- `src_valid` may drop while not granted; that only loses the source its turn.

## Test plan
- **Single packet.** Source 2 sends words 0x11223344 (`last`=0) then 0x55667788 (`last`=1), FULL=0. Required: bytes A2,11,22,33,44,55,66,77,88 on consecutive write strobes, with one idle cycle between each 4-byte group. `pkt_count`=1, `rr_ptr`=3.
- **Round-robin.** All 4 sources request one-word packets continuously from reset. Required: header order A0,A1,A2,A3,A0. No source is granted twice before the others.
- **Backpressure.** FULL held at 1 from the cycle the first payload byte is decided, for 10 cycles. Required: no `TCP_TX_WR` while FULL=1, resume with the same byte, and no byte lost or duplicated.
- **Connection drop.** Drop `TCP_OPEN_ACK` mid-SER of a 3-word packet. Required: `TCP_TX_WR` stops within 1 cycle, and the remaining words are accepted and discarded until `last`. `drop_count`=1, `pkt_count` unchanged, state IDLE.
- **Closed idle.** `TCP_OPEN_ACK`=0 with all `src_valid`=1. Required: `src_ready`=0, `TCP_TX_WR`=0, `busy`=0.
- **Async reset.** Assert `RST` mid-packet, asynchronously between clock edges. Required: all outputs go to their reset values immediately. After release, the next grant starts from source 0.

Source files
------------

// File: rtl/sitcp_tx_arbiter.sv
// Round-robin arbiter that multiplexes N_SRC 32-bit packet sources onto the SiTCP
// TCP transmit byte stream, prefixing each packet with a one-byte source tag.
module sitcp_tx_arbiter #(
  parameter int          N_SRC    = 4,
  parameter logic [7:0]  TAG_BASE = 8'hA0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [32*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]      src_last,
  output logic [N_SRC-1:0]      src_ready,
  input  logic                  TCP_OPEN_ACK,
  input  logic                  TCP_TX_FULL,
  output logic                  TCP_TX_WR,
  output logic [7:0]            TCP_TX_DATA,
  output logic [31:0]           pkt_count,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, SER, DRAIN} state_t;

  state_t      state;
  logic [2:0]  gnt;
  logic [2:0]  rr_ptr;
  logic [2:0]  pick;
  logic [2:0]  next_ptr;
  logic [31:0] word_r;
  logic        last_r;
  logic [1:0]  byte_idx;
  logic [31:0] sel_data;
  logic        sel_valid;
  logic        sel_last;
  logic        accepting;
  logic        hs;
  logic [7:0]  ser_byte;

  // Lowest requester overall, overridden by the lowest requester at or above rr_ptr.
  always_comb begin
    pick = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) pick = 3'(i);
    end
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_valid[i] && (3'(i) >= rr_ptr)) pick = 3'(i);
    end
  end

  always_comb begin
    sel_data  = 32'd0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt == 3'(i)) begin
        sel_data  = src_data[32*i +: 32];
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
      end
    end
  end

  // In DRAIN a captured last word means the packet is already complete; accept nothing more.
  assign accepting = (state == FETCH) || ((state == DRAIN) && !last_r);
  assign hs        = accepting && sel_valid;
  assign next_ptr  = (gnt == 3'(N_SRC - 1)) ? 3'd0 : gnt + 3'd1;
  assign busy      = (state != IDLE);

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = accepting && (gnt == 3'(i));
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    ser_byte = word_r[31:24];
      2'd1:    ser_byte = word_r[23:16];
      2'd2:    ser_byte = word_r[15:8];
      default: ser_byte = word_r[7:0];
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      gnt         <= 3'd0;
      rr_ptr      <= 3'd0;
      word_r      <= 32'd0;
      last_r      <= 1'b0;
      byte_idx    <= 2'd0;
      TCP_TX_WR   <= 1'b0;
      TCP_TX_DATA <= 8'd0;
      pkt_count   <= 32'd0;
      drop_count  <= 16'd0;
    end else begin
      TCP_TX_WR <= 1'b0;
      case (state)
        IDLE: begin
          if (TCP_OPEN_ACK && (|src_valid)) begin
            gnt    <= pick;
            last_r <= 1'b0;
            state  <= HDR;
          end
        end
        HDR: begin
          if (!TCP_OPEN_ACK) begin
            state <= DRAIN;
          end else if (!TCP_TX_FULL) begin
            TCP_TX_WR   <= 1'b1;
            TCP_TX_DATA <= TAG_BASE | {5'd0, gnt};
            state       <= FETCH;
          end
        end
        FETCH: begin
          // A word accepted in the same cycle the link drops must still count toward DRAIN.
          if (hs) begin
            word_r   <= sel_data;
            last_r   <= sel_last;
            byte_idx <= 2'd0;
          end
          if (!TCP_OPEN_ACK) state <= DRAIN;
          else if (hs)       state <= SER;
        end
        SER: begin
          if (!TCP_OPEN_ACK) begin
            state <= DRAIN;
          end else if (!TCP_TX_FULL) begin
            TCP_TX_WR   <= 1'b1;
            TCP_TX_DATA <= ser_byte;
            byte_idx    <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (last_r) begin
                pkt_count <= pkt_count + 32'd1;
                rr_ptr    <= next_ptr;
                state     <= IDLE;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        DRAIN: begin
          if (last_r || (hs && sel_last)) begin
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
